// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART definitions: transmit-feeder FSM encoding, default FIFO depth
// and baud-divider width.
package uart_tx_feeder_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned BAUD_DIV_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock circular FIFO with synchronous flush; level kept as its own
// counter so full/empty come straight from one register.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    // flush wins over both ports: a same-cycle write is discarded
    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds bytes from a bus-side FIFO to a UART transmitter, one start_tx
// pulse per byte, holding data_tx until the transmitter reports done_tx.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    input  logic          done_tx,
    output logic          start_tx,
    output logic [7:0]    data_tx,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          overflow
);

    tx_state_e  state_q, state_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;
    logic       ovf_q, ovf_d;
    logic [7:0] data_q, data_d;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Pop happens on the IDLE->LAUNCH edge; start_tx is a registered
    // copy of "in LAUNCH", so done_tx never reaches start_tx combinationally.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        busy_d     = busy_q;
        data_d     = data_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    data_d     = fifo_rd_data;
                    state_d    = ST_LAUNCH;
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_tx) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_tx = start_q;
    assign data_tx  = data_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus a randomized run against
// a queue-based model of the FIFO and transmitter handshake.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, flush = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0, done_tx = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          start_tx, full, empty, busy, overflow;
    logic [7:0]    data_tx;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    // model: byte queue, transmitter-free flag, overflow flag, last launched byte
    logic [7:0] q[$];
    bit         free_m;
    bit         ovf_m;
    logic [7:0] last_m;
    bit         exp_start;
    int         since;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .wr_en(wr_en),
        .wr_data(wr_data), .clr_ovf(clr_ovf), .done_tx(done_tx),
        .start_tx(start_tx), .data_tx(data_tx), .full(full), .empty(empty),
        .level(level), .busy(busy), .overflow(overflow)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        q.delete();
        free_m = 1'b1;
        ovf_m = 1'b0;
        last_m = 8'h00;
        exp_start = 1'b0;
        since = 0;
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, then
    // return 1 time unit after that edge.
    task automatic drive(input bit en_i, input bit wr_i, input logic [7:0] d_i,
                         input bit done_i, input bit clr_i, input bit flush_i);
        bit full_m, pop_m, done_m;
        en = en_i; wr_en = wr_i; wr_data = d_i; done_tx = done_i;
        clr_ovf = clr_i; flush = flush_i;
        full_m = (q.size() == DEPTH);
        pop_m  = free_m && en_i && (q.size() != 0);
        done_m = done_i && !free_m && (since >= 1);
        if (clr_i) ovf_m = 1'b0;
        else if (wr_i && full_m) ovf_m = 1'b1;
        exp_start = pop_m;
        if (pop_m) begin
            last_m = q.pop_front();
            free_m = 1'b0;
            since = 0;
        end else if (!free_m) begin
            since++;
        end
        if (done_m) free_m = 1'b1;
        if (flush_i) q.delete();
        else if (wr_i && !full_m) q.push_back(d_i);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit en_i);
        drive(en_i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL reset_start got %0h exp 0", start_tx); end
        checks++; if (data_tx !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", data_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", overflow); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", full); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", level); end
        checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL single_early_start got %0h exp 0", start_tx); end
        idle(1'b1);
        checks++; if (start_tx !== 1'b1) begin errors++; $display("FAIL single_start got %0h exp 1", start_tx); end
        checks++; if (data_tx !== 8'hA5) begin errors++; $display("FAIL single_data got %0h exp a5", data_tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0h exp 1", empty); end
        idle(1'b1);
        checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0h exp 0", start_tx); end
        repeat (8) idle(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait got %0h exp 1", busy); end
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got %0h exp 0", busy); end
        checks++; if (data_tx !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %0h exp a5", data_tx); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0h exp 1", full); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %0h exp 0", overflow); end
        drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0h exp 1", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
        drive(1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_priority got %0h exp 0", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_clr_level got %0d exp 16", level); end
    endtask

    task automatic test_drain();
        int found, stray;
        for (int i = 0; i < 16; i++) begin
            found = 0;
            stray = 0;
            for (int w = 0; w < 4 && found == 0; w++) begin
                idle(1'b1);
                if (start_tx === 1'b1) found = 1;
            end
            checks++;
            if (found == 0) begin
                errors++; $display("FAIL drain_timeout byte %0d got no start_tx exp start_tx", i);
            end else begin
                checks++; if (data_tx !== 8'(i)) begin errors++; $display("FAIL drain_data byte %0d got %0h exp %0h", i, data_tx, 8'(i)); end
            end
            repeat (9) begin
                idle(1'b1);
                if (start_tx === 1'b1) stray++;
            end
            checks++; if (stray != 0) begin errors++; $display("FAIL drain_stray_start byte %0d got %0d exp 0", i, stray); end
            drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        stray = 0;
        repeat (4) begin
            idle(1'b1);
            if (start_tx === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL drain_extra_start got %0d exp 0", stray); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0h exp 1", empty); end
    endtask

    task automatic test_simul_write_pop();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_level_pre got %0d exp 5", level); end
        drive(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_level got %0d exp 5", level); end
        checks++; if (start_tx !== 1'b1) begin errors++; $display("FAIL simul_start got %0h exp 1", start_tx); end
        checks++; if (data_tx !== 8'h30) begin errors++; $display("FAIL simul_data got %0h exp 30", data_tx); end
        repeat (3) idle(1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_done got %0h exp 0", busy); end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        checks++; if (busy !== 1'b0 || start_tx !== 1'b0) begin errors++; $display("FAIL spurious_done busy/start got %0h/%0h exp 0/0", busy, start_tx); end
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL spurious_level got %0d exp 5", level); end
    endtask

    task automatic test_flush();
        int stray;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_idle level/empty got %0d/%0h exp 0/1", level, empty); end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL flush_pre_level got %0d exp 3", level); end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (data_tx !== 8'h50) begin errors++; $display("FAIL flush_data got %0h exp 50", data_tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %0h exp 1", busy); end
        repeat (3) idle(1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_done got %0h exp 0", busy); end
        stray = 0;
        repeat (4) begin
            idle(1'b1);
            if (start_tx === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL flush_stray_start got %0d exp 0", stray); end
    endtask

    task automatic test_reset_mid();
        int stray;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        checks++; if (busy !== 1'b1 || level !== 5'd4) begin errors++; $display("FAIL rstmid_pre busy/level got %0h/%0d exp 1/4", busy, level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (start_tx !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl start/busy/ovf got %0h/%0h/%0h exp 0/0/0", start_tx, busy, overflow); end
        checks++; if (data_tx !== 8'h00) begin errors++; $display("FAIL rstmid_data got %0h exp 00", data_tx); end
        checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rstmid_fifo level/empty/full got %0d/%0h/%0h exp 0/1/0", level, empty, full); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        stray = 0;
        repeat (5) begin
            idle(1'b1);
            if (start_tx === 1'b1 || busy === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_no_start got %0d exp 0", stray); end
    endtask

    task automatic test_random();
        bit en_i, wr_i, done_i, clr_i;
        int dly;
        dly = 1;
        for (int c = 0; c < 500; c++) begin
            en_i  = ($urandom_range(0, 3) != 0);
            wr_i  = ($urandom_range(0, 1) == 1);
            clr_i = ($urandom_range(0, 19) == 0);
            if (!free_m) done_i = (since >= dly);
            else done_i = ($urandom_range(0, 15) == 0);
            drive(en_i, wr_i, 8'($urandom), done_i, clr_i, 1'b0);
            if (exp_start) dly = $urandom_range(1, 6);
            checks++; if (start_tx !== exp_start) begin errors++; $display("FAIL rand_start cyc %0d got %0h exp %0h", c, start_tx, exp_start); end
            checks++; if (data_tx !== last_m) begin errors++; $display("FAIL rand_data cyc %0d got %0h exp %0h", c, data_tx, last_m); end
            checks++; if (level !== LW'(q.size())) begin errors++; $display("FAIL rand_level cyc %0d got %0d exp %0d", c, level, q.size()); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_flags cyc %0d empty/full got %0h/%0h exp size %0d", c, empty, full, q.size()); end
            checks++; if (busy !== !free_m) begin errors++; $display("FAIL rand_busy cyc %0d got %0h exp %0h", c, busy, !free_m); end
            checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL rand_ovf cyc %0d got %0h exp %0h", c, overflow, ovf_m); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill_overflow();
        test_drain();
        test_simul_write_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, minimum 2.
REQ-002 Parameter LW, default $clog2(DEPTH)+1, width of the level output.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  permits launching new bytes; does not gate FIFO writes.
REQ-006 flush  input  1  synchronous clear of FIFO contents.
REQ-007 wr_en  input  1  write strobe from the bus side.
REQ-008 wr_data  input  8  byte to enqueue.
REQ-009 clr_ovf  input  1  clears the overflow flag.
REQ-010 done_tx  input  1  single-cycle pulse from the UART transmitter at the end of the stop bit.
REQ-011 start_tx  output  1  single-cycle launch pulse to the UART transmitter.
REQ-012 data_tx  output  8  byte presented to the transmitter; registered.
REQ-013 full, empty  output  1 each  FIFO status.
REQ-014 level  output  LW  number of stored bytes, 0..DEPTH.
REQ-015 busy  output  1  high from pop until done_tx is received.
REQ-016 overflow  output  1  sticky; set when a write is dropped.

Function
REQ-017 FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap DEPTH-1 -> 0; level is maintained as a separate counter.
REQ-018 Write: accepted when wr_en=1 and full=0; when full=1, the write is dropped and overflow is set the next cycle, even if a pop occurs in the same cycle.
REQ-019 Simultaneous accepted write and pop: level is unchanged and both pointers advance.
REQ-020 FSM states: IDLE, LAUNCH, WAIT; encoding width 2.
REQ-021 IDLE -> LAUNCH when en=1 and empty=0: the head byte is popped into the data_tx register on the same edge.
REQ-022 LAUNCH -> WAIT unconditionally; start_tx=1 only while in LAUNCH, giving exactly one cycle.
REQ-023 WAIT -> IDLE on done_tx=1; done_tx in any other state is ignored.
REQ-024 data_tx SHALL remain stable from the pop until the cycle after done_tx.
REQ-025 Latency: a write at edge N into an empty FIFO with en=1 and FSM in IDLE gives pop at N+1, start_tx high during the cycle after N+1, and next-byte pop on the edge after done_tx at the earliest.
REQ-026 busy=1 in LAUNCH and WAIT.
REQ-027 en deasserted in LAUNCH or WAIT: the current byte completes normally, and no further pop occurs until en=1.
REQ-028 flush: pointers and level go to 0, and a write in the same cycle is discarded; the FSM and the byte in flight are unaffected.
REQ-029 clr_ovf has priority over a same-cycle overflow set, so the flag is cleared.
REQ-030 full = (level==DEPTH); empty = (level==0).

Reset
REQ-031 rst_n=0 asynchronously forces: FSM=IDLE, pointers=0, level=0, start_tx=0, data_tx=8'h00, busy=0, overflow=0, empty=1, full=0.
REQ-032 Reset mid-transfer abandons the byte in flight and all queued bytes; a done_tx arriving after reset release in IDLE is ignored.
REQ-033 FIFO storage array is not reset.

Structure
REQ-034 The FSM state encoding and the default DEPTH constant belong in the shared UART package alongside the baud-divider width.
REQ-035 One sub-module, sync_fifo (parameterised width/depth, with flush), holds the storage and pointers; the FSM and output registers live in uart_tx_feeder.
REQ-036 Target size: 150-250 lines total; no combinational path from done_tx to start_tx.

Verification
REQ-037 Reset release, write 8'hA5 with en=1 -> start_tx single pulse two edges after write, data_tx=8'hA5, busy=1 until done_tx; empty=1 after pop.
REQ-038 en=0, write 16 bytes 8'h00..8'h0F -> full=1, level=16; 17th write -> overflow=1, level stays 16; clr_ovf -> overflow=0.
REQ-039 Then en=1, done_tx pulsed 10 cycles after each start_tx -> 16 start_tx pulses, data_tx sequence 8'h00..8'h0F in order, pointers wrap; empty=1 at end.
REQ-040 Write on the same edge as a pop at level=5 -> level stays 5; a spurious done_tx in IDLE -> no state change.
REQ-041 flush while in WAIT with level=3 -> level=0, data_tx unchanged, byte completes on done_tx, FSM returns to IDLE with no further start_tx.
REQ-042 rst_n low during WAIT with level=4 -> all outputs at reset values immediately (asynchronously); after release, no start_tx without a new write.
